// File: rtl/sea_frame_loader_if.sv
// Byte-stream / frame handshake bundle between a byte source, the frame loader and the cipher core.
interface sea_frame_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        key_keep;
  logic [47:0] lo;
  logic [47:0] ro;
  logic [47:0] ko;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;

  modport master (
    output in_data, in_valid, key_keep, out_ready,
    input  in_ready, lo, ro, ko, out_valid, frame_err
  );

  modport slave (
    input  in_data, in_valid, key_keep, out_ready,
    output in_ready, lo, ro, ko, out_valid, frame_err
  );
endinterface

// File: rtl/sea_frame_loader.sv
// Assembles an MSB-first byte stream into lo/ro/ko frames for the cipher core.
// Optional SEA_LDR_KEYKEEP_EN: 12-byte frames that reuse the stored key.
module sea_frame_loader #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic               clk,
  input logic               rst_n,
  input logic               ena,
  sea_frame_loader_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [15:0]    tmo_q, tmo_d;
  logic [143:0]   frame_q, frame_d;
  logic           frame_err_q, frame_err_d;
  logic [4:0]     last_idx;
  logic           accept;

`ifdef SEA_LDR_KEYKEEP_EN
  logic keep_q, keep_d;
  // key_keep is only meaningful on the first byte; later bytes use the latched value
  assign last_idx = ((state_q == StIdle) ? bus.key_keep : keep_q) ? 5'd11 : 5'd17;
`else
  assign last_idx = 5'd17;
`endif

  assign bus.in_ready  = ena && (state_q != StHold);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.lo        = frame_q[143:96];
  assign bus.ro        = frame_q[95:48];
  assign bus.ko        = frame_q[47:0];
  assign bus.out_valid = (state_q == StHold);
  assign bus.frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    frame_d     = frame_q;
    frame_err_d = 1'b0;
`ifdef SEA_LDR_KEYKEEP_EN
    keep_d      = keep_q;
`endif
    if (ena) begin
      unique case (state_q)
        StIdle, StLoad: begin
          if (accept) begin
            // Byte slots are written in place so a short frame never touches ko
            for (int i = 0; i < 18; i++) begin
              if (cnt_q == 5'(i)) frame_d[143 - 8*i -: 8] = bus.in_data;
            end
            tmo_d = 16'd0;
`ifdef SEA_LDR_KEYKEEP_EN
            if (state_q == StIdle) keep_d = bus.key_keep;
`endif
            if (cnt_q == last_idx) begin
              state_d = StHold;
              cnt_d   = 5'd0;
            end else begin
              state_d = StLoad;
              cnt_d   = cnt_q + 5'd1;
            end
          end else if ((state_q == StLoad) && (TIMEOUT_CYC != 0)) begin
            if (tmo_q + 16'd1 == 16'(TIMEOUT_CYC)) begin
              frame_err_d = 1'b1;
              cnt_d       = 5'd0;
              tmo_d       = 16'd0;
              state_d     = StIdle;
            end else begin
              tmo_d = tmo_q + 16'd1;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 5'd0;
      tmo_q       <= 16'd0;
      frame_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef SEA_LDR_KEYKEEP_EN
      keep_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      frame_q     <= frame_d;
      frame_err_q <= frame_err_d;
`ifdef SEA_LDR_KEYKEEP_EN
      keep_q      <= keep_d;
`endif
    end
  end

endmodule

// File: tb/tb_sea_frame_loader.sv
// Self-checking bench for sea_frame_loader: directed tables, hand sequences and a random run
// compared against a byte-queue frame model.
module tb_sea_frame_loader;
  localparam int unsigned TMO = 4;
`ifdef SEA_LDR_KEYKEEP_EN
  localparam bit KK = 1'b1;
`else
  localparam bit KK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  sea_frame_loader_if bus ();

  sea_frame_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: bytes collected so far, hold flag, idle-gap count, expected frame
  logic [7:0]  m_q[$];
  bit          m_hold, m_kk, m_err, m_key_ok;
  int          m_gap;
  logic [47:0] m_lo, m_ro, m_ko, m_key;

  // Values sampled at the falling edge of the last step
  logic        s_ir, s_ov, s_err;
  logic [47:0] s_lo, s_ro, s_ko;

  typedef struct {
    logic       e;
    logic       v;
    logic [7:0] d;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
  } tv_t;
  tv_t tbl[$];

  function automatic void chk(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_hold = 0; m_kk = 0; m_err = 0; m_key_ok = 1; m_gap = 0;
    m_lo = '0; m_ro = '0; m_ko = '0; m_key = '0;
  endfunction

  task automatic step(input logic e, input logic v, input logic [7:0] d, input logic ordy,
                      input logic kk);
    bit n_err;
    ena = e; bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy; bus.key_keep = kk;
    @(negedge clk);
    s_ir = bus.in_ready; s_ov = bus.out_valid; s_err = bus.frame_err;
    s_lo = bus.lo; s_ro = bus.ro; s_ko = bus.ko;
    chk("in_ready", 48'(s_ir), 48'(e && !m_hold));
    chk("out_valid", 48'(s_ov), 48'(m_hold));
    chk("frame_err", 48'(s_err), 48'(m_err));
    if (m_hold) begin
      chk("lo", s_lo, m_lo);
      chk("ro", s_ro, m_ro);
      if (!m_kk || m_key_ok) chk("ko", s_ko, m_ko);
    end
    n_err = 0;
    if (e) begin
      if (m_hold) begin
        if (ordy) m_hold = 0;
      end else if (v) begin
        if (m_q.size() == 0) m_kk = KK ? kk : 1'b0;
        m_q.push_back(d);
        m_gap = 0;
        if (m_q.size() == (m_kk ? 12 : 18)) begin
          for (int i = 0; i < 6; i++) begin
            m_lo = {m_lo[39:0], m_q[i]};
            m_ro = {m_ro[39:0], m_q[i+6]};
          end
          if (m_kk) m_ko = m_key;
          else begin
            for (int i = 12; i < 18; i++) m_ko = {m_ko[39:0], m_q[i]};
            m_key = m_ko;
            m_key_ok = 1;
          end
          m_hold = 1;
          m_q.delete();
        end
      end else if (m_q.size() > 0 && TMO != 0) begin
        m_gap++;
        if (m_gap == TMO) begin
          n_err = 1;
          if (m_q.size() > 12) m_key_ok = 0; // dropped frame may have clobbered the key
          m_q.delete();
          m_gap = 0;
        end
      end
    end
    m_err = n_err;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_lo", bus.lo, 48'h0);
    chk("rst_ro", bus.ro, 48'h0);
    chk("rst_ko", bus.ko, 48'h0);
    chk("rst_out_valid", 48'(bus.out_valid), 48'h0);
    chk("rst_frame_err", 48'(bus.frame_err), 48'h0);
    chk("rst_in_ready", 48'(bus.in_ready), 48'(ena));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int err_cnt, err_idx;

  initial begin
    rst_n = 1'b1; ena = 1'b1;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0; bus.key_keep = 0;
    #2;
    pulse_reset();

    // Back-to-back 0x01..0x12 with out_ready held high
    for (int i = 1; i <= 18; i++) step(1, 1, 8'(i), 1, 0);
    step(1, 0, 8'h00, 1, 0);
    chk("b2b_out_valid", 48'(s_ov), 48'h1);
    chk("b2b_lo", s_lo, 48'h010203040506);
    chk("b2b_ro", s_ro, 48'h0708090A0B0C);
    chk("b2b_ko", s_ko, 48'h0D0E0F101112);
    step(1, 0, 8'h00, 1, 0);
    chk("b2b_ov_drop", 48'(s_ov), 48'h0);

    // Back-pressure table: full frame, 10 stalled cycles, handshake, then ready again
    for (int i = 0; i < 18; i++) tbl.push_back('{1, 1, 8'(8'h30 + i), 0, 1, 0});
    for (int i = 0; i < 10; i++) tbl.push_back('{1, 1, 8'hFF, 0, 0, 1});
    tbl.push_back('{1, 0, 8'h00, 1, 0, 1});
    tbl.push_back('{1, 0, 8'h00, 0, 1, 0});
    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].v, tbl[i].d, tbl[i].ordy, 0);
      chk("tbl_in_ready", 48'(s_ir), 48'(tbl[i].exp_ir));
      chk("tbl_out_valid", 48'(s_ov), 48'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) chk("tbl_lo", s_lo, 48'h303132333435);
    end

    // Timeout: 5 bytes then silence
    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'h50 + i), 0, 0);
    err_cnt = 0; err_idx = -1;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 8'h00, 0, 0);
      if (s_err) begin err_cnt++; err_idx = k; end
    end
    chk("tmo_pulses", 48'(err_cnt), 48'd1);
    chk("tmo_when", 48'(err_idx), 48'd4);
    for (int i = 0; i < 18; i++) step(1, 1, 8'(8'hA0 + i), 0, 0);
    step(1, 0, 8'h00, 1, 0);
    chk("tmo_next_lo", s_lo, 48'hA0A1A2A3A4A5);

    // Reset after byte 9, then a clean frame
    for (int i = 0; i < 9; i++) step(1, 1, 8'(8'h60 + i), 0, 0);
    pulse_reset();
    for (int i = 0; i < 18; i++) step(1, 1, 8'(8'h70 + i), 0, 0);
    step(1, 0, 8'h00, 1, 0);
    chk("post_rst_lo", s_lo, 48'h707172737475);
    chk("post_rst_ko", s_ko, 48'h7C7D7E7F8081);

    // ena low for 6 cycles mid-frame with in_valid high
    for (int i = 0; i < 7; i++) step(1, 1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'hEE, 1, 0);
      chk("ena_off_ir", 48'(s_ir), 48'h0);
      chk("ena_off_err", 48'(s_err), 48'h0);
    end
    for (int i = 7; i < 18; i++) step(1, 1, 8'(8'h80 + i), 0, 0);
    step(1, 0, 8'h00, 1, 0);
    chk("ena_ov", 48'(s_ov), 48'h1);
    chk("ena_ro", s_ro, 48'h868788898A8B);

`ifdef SEA_LDR_KEYKEEP_EN
    for (int i = 1; i <= 18; i++) step(1, 1, 8'(i), 0, 0);
    step(1, 0, 8'h00, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 8'(8'hC0 + i), 0, (i == 0));
    step(1, 0, 8'h00, 1, 0);
    chk("kk_ov", 48'(s_ov), 48'h1);
    chk("kk_lo", s_lo, 48'hC0C1C2C3C4C5);
    chk("kk_ko", s_ko, 48'h0D0E0F101112);
`endif

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      step(($urandom % 8) != 0, ($urandom % 10) < 7, 8'($urandom), $urandom % 2,
           $urandom % 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
